// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - sequential 32x32->64 unsigned shift-and-add multiplier with valid/ready handshakes
//
// Purpose:
//   Accepts an operand pair plus tag, steps one ripple adder (add32bit)
//   through 32 shift-and-add iterations, then presents the 64-bit product
//   and the tag until the consumer takes it.
//
// Optional feature macro: ZERO_BYPASS_EN
//   When defined, a request with a zero operand skips the RUN phase and
//   goes from IDLE straight to DONE with a zero product.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand request valid
//   in_ready   out  request can be accepted (IDLE only)
//   in_a       in   multiplicand [WIDTH-1:0], unsigned
//   in_b       in   multiplier   [WIDTH-1:0], unsigned
//   in_tag     in   request tag  [TAG_W-1:0]
//   out_valid  out  product valid (DONE only)
//   out_ready  in   consumer accepts product
//   out_prod   out  product [2*WIDTH-1:0]; holds last value outside DONE
//   out_tag    out  tag of the request that produced out_prod
//   busy       out  high in RUN or DONE

module add32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [32:0] w_c;

  always_comb begin
    w_c      = '0;
    o_sum    = '0;
    w_c[0]   = i_cin;
    for (int i = 0; i < 32; i++) begin
      o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c[32];
  end

endmodule

module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  // The datapath is sized to the fixed 32-bit adder instance; WIDTH only
  // documents that and must stay at 32.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [5:0]         r_cnt;
  logic [TAG_W-1:0]   r_tag;
  logic [2*WIDTH-1:0] r_prod;
  logic [TAG_W-1:0]   r_out_tag;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [2*WIDTH-1:0] w_acc_step;
  logic               w_zero;

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_last   = (r_state == ST_RUN) && (r_cnt == 6'd31);
  assign w_zero   = (in_a == '0) || (in_b == '0);

  // Add the multiplicand only when the current multiplier bit is set.
  assign w_addend = r_acc_lo[0] ? r_mcand : '0;

  add32bit u_add (
    .i_a    (r_acc_hi),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Carry-out lands in acc_hi[31]; the used multiplier bit falls off acc_lo[0].
  assign w_acc_step = {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef ZERO_BYPASS_EN
          w_state_nxt = w_zero ? ST_DONE : ST_RUN;
`else
          w_state_nxt = ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (r_cnt == 6'd31) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_cnt     <= '0;
      r_tag     <= '0;
      r_prod    <= '0;
      r_out_tag <= '0;
    end else if (w_accept) begin
      r_mcand  <= in_a;
      r_acc_hi <= '0;
      r_cnt    <= '0;
      r_tag    <= in_tag;
`ifdef ZERO_BYPASS_EN
      if (w_zero) begin
        r_acc_lo  <= '0;
        r_prod    <= '0;
        r_out_tag <= in_tag;
      end else begin
        r_acc_lo <= in_b;
      end
`else
      r_acc_lo <= in_b;
`endif
    end else if (r_state == ST_RUN) begin
      {r_acc_hi, r_acc_lo} <= w_acc_step;
      r_cnt                <= r_cnt + 6'd1;
      // Publish on the final step so out_prod is already valid in DONE and
      // keeps the last product after the handshake.
      if (w_last) begin
        r_prod    <= w_acc_step;
        r_out_tag <= r_tag;
      end
    end
  end

  assign out_prod = r_prod;
  assign out_tag  = r_out_tag;

`ifndef ZERO_BYPASS_EN
  logic w_unused;
  assign w_unused = w_zero;
`endif

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - randomized self-checking bench for mul_seq_ctrl

module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_prod;
  logic [3:0]  out_tag;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(32), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: edges between accept and first visible out_valid.
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 0;
`endif
    return 32;
  endfunction

  // One full transaction. jam keeps in_valid high with fresh operands while busy.
  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input int stall, input bit jam);
    logic [63:0] exp_prod;
    int lat;
    exp_prod = {32'd0, a} * {32'd0, b};
    @(negedge clk);
    chk("acc_rdy", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(negedge clk);
    if (jam) begin
      in_a = $urandom; in_b = $urandom; in_tag = 4'($urandom);
    end else begin
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom;
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (lat == 5) begin
        chk("run_rdy", {63'd0, in_ready}, 64'd0);
        chk("run_busy", {63'd0, busy}, 64'd1);
      end
      @(negedge clk);
      lat++;
      if (jam) begin
        in_a = $urandom; in_b = $urandom; in_tag = 4'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("latency", 64'(lat), 64'(ref_lat(a, b)));
    chk("prod", out_prod, exp_prod);
    chk("tag", {60'd0, out_tag}, {60'd0, tag});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_vld", {63'd0, out_valid}, 64'd1);
      chk("hold_prod", out_prod, exp_prod);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_vld", {63'd0, out_valid}, 64'd0);
    chk("post_rdy", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rdy", {63'd0, in_ready}, 64'd1);
    chk("rst_vld", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_prod", out_prod, 64'd0);
    chk("rst_tag", {60'd0, out_tag}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_req(32'd3, 32'd5, 4'hA, 0, 1'b0);
    run_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3, 0, 1'b0);
    run_req(32'h8000_0000, 32'd2, 4'h5, 0, 1'b0);
    run_req(32'h1234_5678, 32'h9ABC_DEF0, 4'h7, 10, 1'b0);
    run_req(32'd11, 32'd13, 4'h2, 0, 1'b1);
    run_req(32'd0, 32'd9, 4'h9, 1, 1'b0);

    // Reset in the middle of RUN discards the product.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'd100; in_b = 32'd200; in_tag = 4'hE;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_prod", out_prod, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) chk("spurious_vld", {63'd0, out_valid}, 64'd0);
    end
    chk("idle_vld", {63'd0, out_valid}, 64'd0);
    run_req(32'd7, 32'd6, 4'h1, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 4))
        0: begin ra = 32'd0; rb = $urandom; end
        1: begin ra = 32'hFFFF_FFFF; rb = $urandom; end
        2: begin ra = $urandom; rb = 32'd1; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      run_req(ra, rb, 4'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
